regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between NREQ requesters using round-robin arbitration.
- Also runs a post-reset clear sequence that writes zero to every register address before any requester is served.
- Sits between the datapath write sources (ALU writeback, load unit, debug port) and the register file's we/waddr/wdata inputs.

Parameters:
NREQ, 2, number of requesters (1..8)
DEPTH, 32, number of register file entries cleared after reset
AW, 5, address width (log2 DEPTH)
DW, 32, data width
ZERO_REG, 1, if 1, address 0 is hardwired: writes to it are granted but suppressed

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; held until granted
wr_addr_in  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
wr_data_in  input  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
gnt  output  NREQ  one-hot grant, combinational, valid in the same cycle as the write
busy  output  1  high while the clear sequence runs
rf_we  output  1  register file write enable
rf_waddr  output  AW  register file write address
rf_wdata  output  DW  register file write data

Behaviour:
- State register: CLEAR or ARB. Counter clr_cnt (AW bits). Round-robin pointer last (index of the last granted requester).
- Reset: rst high at a rising edge sets state=CLEAR, clr_cnt=0, last=NREQ-1. Requester 0 is therefore highest priority after clear. Reset takes effect from any state, including mid-clear, where the clear restarts at address 0.
- Output values while rst is asserted:
  - From the edge onward (state=CLEAR, clr_cnt=0): busy=1, rf_we=1, rf_waddr=0, rf_wdata=0, gnt=0.
  - No requester is ever granted while rst is high.
- CLEAR state:
  - Every cycle: rf_we=1, rf_waddr=clr_cnt, rf_wdata=0, gnt=0, busy=1. req is ignored; requests stay pending.
  - clr_cnt increments each edge.
  - On the edge where clr_cnt==DEPTH-1, the state moves to ARB.
  - The clear takes exactly DEPTH cycles.
- ARB state, busy=0:
  - Winner: the first requester with req high, scanning indices last+1, last+2, ... modulo NREQ.
  - No req high: gnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, last unchanged.
  - A winner w exists:
    - gnt = (1<<w).
    - rf_waddr = addr[w], rf_wdata = data[w].
    - rf_we = 1, except 0 when ZERO_REG=1 and addr[w]==0. The grant is still given.
    - last <= w at the edge.
- Latency is zero: the write commits at the rising edge ending the grant cycle.
- Handshake rules:
  - Requester i must hold req, address and data stable until it sees gnt[i] high in a cycle.
  - The request completes at that cycle's edge.
  - The requester may drop req or present a new request the following cycle.
  - A requester holding req continuously gets back-to-back grants only when no other requester is pending.
- Fairness: with k requesters continuously pending, each is granted exactly once in every k consecutive ARB cycles.
- Exactly one grant per cycle maximum; gnt is always one-hot or zero.
- gnt, rf_* and busy are combinational from registered state plus inputs. No combinational path exists from gnt back to req inside the block.

Test Plan:
- Clear sequence: assert rst for 1 cycle, then release → busy=1 for 32 cycles; rf_we=1 with rf_waddr 0,1,...,31 and rf_wdata=0; busy=0 at cycle 33; a req[1] held throughout gets no gnt until busy=0.
- Single requester: after clear, req=2'b01, addr0=5, data0=32'hACE5F8ED for 1 cycle → gnt=2'b01, rf_we=1, rf_waddr=5, rf_wdata=32'hACE5F8ED in that same cycle.
- Contention: req=2'b11 held for 4 cycles (data0=32'h1EE7BA17, data1=32'hACE5F8ED) → gnt sequence 01,10,01,10; rf_wdata alternates accordingly.
- Zero register: req=2'b10, addr1=0, data1=32'hFFFFFFFF → gnt=2'b10, rf_we=0. The same stimulus with ZERO_REG=0 gives rf_we=1.
- Reset mid-clear: assert rst when clr_cnt=17 → the next cycle shows rf_waddr=0, busy=1, and a full 32-cycle clear follows.
- Reset mid-arbitration: while granting requester 0 with last=0, assert rst → gnt=0 from the following cycle; after re-clear, contention on 2'b11 grants requester 0 first.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus between datapath write sources and the register file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr_in;
  logic [NREQ*DW-1:0] wr_data_in;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  modport master (
    output req, wr_addr_in, wr_data_in,
    input  gnt, busy, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req, wr_addr_in, wr_data_in,
    output gnt, busy, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port; zero-fills every entry after reset.
// Zero latency: grant and write happen in the same cycle, requesters hold until granted.
module regfile_write_arbiter #(
  parameter int NREQ     = 2,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR, ARB} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [IW-1:0] last;

  logic          win_vld;
  logic [IW-1:0] win;

  // Scan starts one past the last winner so the previous grantee is checked last.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  always_comb begin
    bus.gnt      = '0;
    bus.busy     = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (state == CLEAR) begin
      bus.busy     = 1'b1;
      bus.rf_we    = 1'b1;
      bus.rf_waddr = clr_cnt;
    end else if (win_vld && !rst) begin
      bus.gnt      = NREQ'(1) << win;
      bus.rf_waddr = bus.wr_addr_in[int'(win)*AW +: AW];
      bus.rf_wdata = bus.wr_data_in[int'(win)*DW +: DW];
      // Writes to a hardwired r0 are acknowledged but never reach the array.
      bus.rf_we    = !(ZERO_REG && (bus.wr_addr_in[int'(win)*AW +: AW] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      last    <= IW'(NREQ - 1);
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) state <= ARB;
        end
        ARB: begin
          if (win_vld) last <= win;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule
